// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants and types for the sequential 12-by-6
//               restoring divider: default operand widths, the controller
//               state encoding and the iteration counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand widths. The dividend width is also the quotient width.
    // The divisor width is also the remainder width.
    localparam int DEF_DIVIDEND_W = 12;
    localparam int DEF_DIVISOR_W  = 6;

    // The counter is loaded with DIVIDEND_W, so it needs room for that value.
    localparam int DEF_CNT_W = $clog2(DEF_DIVIDEND_W + 1);

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. The partial
//               remainder is shifted left and the next dividend bit is
//               brought in. The divisor is subtracted only when it fits.
// Ports       : r_i       - partial remainder (DIVISOR_W+1 bits)
//               q_msb_i   - dividend/quotient bit being shifted in
//               divisor_i - divisor
//               r_o       - next partial remainder
//               q_bit_o   - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DIVISOR_W = 6
) (
    input  logic [DIVISOR_W:0]   r_i,
    input  logic                 q_msb_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   r_o,
    output logic                 q_bit_o
);

    localparam int RW = DIVISOR_W + 1;

    logic [RW:0] w_shift;
    logic        w_ge;

    // The full partial remainder feeds the shift. Its top bit is always zero
    // after a restoring step. It is kept in the compare anyway, so that the
    // compare stays exact.
    assign w_shift = {r_i, q_msb_i};
    assign w_ge    = (w_shift >= {2'b00, divisor_i});
    assign r_o     = w_ge ? RW'(w_shift - {2'b00, divisor_i}) : w_shift[RW-1:0];
    assign q_bit_o = w_ge;

endmodule : div_step
`default_nettype wire

// File: rtl/div_12by6_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_12by6_seq
// Description : Sequential unsigned restoring divider. It takes one
//               DIVIDEND_W-bit by DIVISOR_W-bit division at a time, with a
//               valid/ready handshake on input and on output. A nonzero
//               divisor takes DIVIDEND_W cycles from accept to out_valid. A
//               zero divisor finishes in one cycle and flags div_by_zero.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - operand handshake (ready only in IDLE)
//               dividend, divisor     - unsigned operands
//               out_valid/out_ready   - result handshake (valid only in DONE)
//               quotient, remainder   - unsigned results
//               div_by_zero           - result came from a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module div_12by6_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    // Reject an illegal width combination when the design is elaborated.
    generate
        if (DIVISOR_W > DIVIDEND_W) begin : g_bad_widths
            $error("div_12by6_seq: DIVISOR_W must not exceed DIVIDEND_W");
        end
    endgenerate

    div_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]  quot_q, quot_d;   // dividend in, quotient out
    logic [DIVISOR_W:0]     rem_q, rem_d;     // one extra bit for the compare
    logic [DIVISOR_W-1:0]   dsr_q, dsr_d;
    logic                   dbz_q, dbz_d;

    logic [DIVISOR_W:0]     w_step_r;
    logic                   w_step_qbit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r_i       (rem_q),
        .q_msb_i   (quot_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .r_o       (w_step_r),
        .q_bit_o   (w_step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    quot_d = dividend;
                    dsr_d  = divisor;
                    rem_d  = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CNT_W'(DIVIDEND_W);
                        dbz_d   = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                // The quotient register shifts left. Each dividend bit leaves
                // at the top and a quotient bit enters at the bottom.
                rem_d  = w_step_r;
                quot_d = {quot_q[DIVIDEND_W-2:0], w_step_qbit};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    // The handshake outputs decode only the registered state.
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q[DIVISOR_W-1:0];
    assign div_by_zero = dbz_q;

endmodule : div_12by6_seq
`default_nettype wire

// File: doc/div_12by6_seq.md
# div_12by6_seq

Sequential unsigned restoring divider: a 12-bit dividend by a 6-bit divisor, producing a 12-bit quotient and a 6-bit remainder. It is the inverse-direction companion to the 6x6 multiplier benchmarks. Its checking role is to take a 12-bit product and one 6-bit operand and recover the other operand, so that a multiplier's output can be inverted and scored in the error-evaluation flow. It has a valid/ready handshake on input and output and processes one division at a time.

## Interface
- DIVIDEND_W, 12: dividend and quotient width.
- DIVISOR_W, 6: divisor and remainder width; must satisfy DIVISOR_W <= DIVIDEND_W.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept; high only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- out_valid  output  1  result held; high only in DONE.
- out_ready  input  1  consumer takes result.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  result is from a zero divisor.

## Operation
- States are IDLE, CALC and DONE.
- **Reset:**
  - state goes to IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - The iteration counter and the partial remainder are cleared.
- **IDLE:**
  - An accept is in_valid && in_ready at an edge.
  - On accept, dividend is latched into the quotient shift register, divisor is latched, and the partial remainder (DIVISOR_W+1 bits) is set to 0.
  - If divisor==0, the next state is DONE with quotient = all ones, remainder = 0 and div_by_zero = 1.
  - Otherwise the next state is CALC, the counter is loaded with DIVIDEND_W and div_by_zero is set to 0.
- **CALC**, one restoring step per cycle:
  - r' = {r[DIVISOR_W-1:0], q[MSB]}, then q shifts left by one.
  - If r' >= {0,divisor}: r = r' - divisor and the new q LSB = 1. Otherwise r = r' and the new q LSB = 0.
  - The counter decrements. The step that takes the counter from 1 to 0 also moves the state to DONE.
  - Arithmetic is unsigned. The partial remainder is one bit wider than the divisor, so the compare never overflows; the final remainder fits in DIVISOR_W bits.
- **DONE:**
  - quotient, remainder and div_by_zero are held stable while out_valid=1.
  - On out_valid && out_ready at an edge, the next state is IDLE.
  - in_valid is ignored in DONE; there is no same-cycle re-accept.
- in_valid in CALC or DONE is not accepted, because in_ready=0. The source holds its data until accepted.
- quotient/remainder outputs are the internal registers. Their value outside DONE is unspecified apart from reset.
- **Reset mid-operation:** rst in any state aborts the operation and the next cycle is the full reset state. No out_valid is produced for the aborted operation.

## Timing
- The accept edge is E0.
- Nonzero divisor:
  - CALC occupies the cycles after E0 through E12 (DIVIDEND_W steps).
  - out_valid=1 after edge E12, i.e. DIVIDEND_W cycles from accept to out_valid.
- Zero divisor: out_valid=1 after E0 (1 cycle).
- Retire edge ER (out_valid && out_ready): in_ready=1 after ER, so the next accept is possible at ER+1.
- Throughput is one division per DIVIDEND_W+2 cycles with out_ready held high.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.

## Structure
- Package div_pkg holds:
  - DIVIDEND_W and DIVISOR_W default constants.
  - the state enum (IDLE, CALC, DONE).
  - the counter width, $clog2(DIVIDEND_W+1).
- One combinational sub-module, div_step:
  - inputs: r, q MSB, divisor.
  - outputs: next r and quotient bit.
  - It is instantiated once in the top, which holds the FSM, counter and registers.

## Test plan
- Exact-product inversion: dividend=4095, divisor=63 -> after 12 cycles quotient=65, remainder=0, div_by_zero=0; likewise 36/6 -> 6 r0.
- General case: 1000/7 -> quotient=142, remainder=6; 5/9 -> quotient=0, remainder=5; 4095/1 -> quotient=4095, remainder=0.
- Divide by zero: 100/0 -> out_valid one cycle after accept, quotient=12'hFFF, remainder=0, div_by_zero=1; then 100/3 -> 33 r1 with div_by_zero=0.
- Backpressure:
  - out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout.
  - in_valid presented during CALC -> not accepted; accepted only after retire.
- Reset mid-CALC: assert rst 4 cycles after accepting 1000/7 -> next cycle in_ready=1 and out_valid=0. A new 200/9 completes correctly (22 r2).
- Exhaustive sweep: all 4096x63 nonzero-divisor pairs back-to-back with random out_ready -> quotient*divisor+remainder==dividend and remainder<divisor for every result, with no lost or duplicated transactions.
